lcd_timing_gen: RTL and testbench
=================================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 41, meaning horizontal sync width in clk_lcd cycles.
REQ-002 The block SHALL have parameter H_BP, default 2, meaning horizontal back porch in cycles.
REQ-003 The block SHALL have parameter H_ACTIVE, default 480, meaning visible pixels per line.
REQ-004 The block SHALL have parameter H_FP, default 2, meaning horizontal front porch in cycles.
REQ-005 The block SHALL have parameter V_SYNC, default 10, meaning vertical sync width in lines.
REQ-006 The block SHALL have parameters V_BP, default 2; V_ACTIVE, default 272; and V_FP, default 2, meaning vertical back porch, visible lines and front porch.
REQ-007 The block SHALL have parameter PWR_FRAMES, default 4, meaning frames held with disp high before pixel output is enabled.
REQ-008 The block SHALL have port clk_lcd, input, 1 bit: pixel clock; one clock domain, all logic on its rising edge.
REQ-009 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 The block SHALL have port en, input, 1 bit: display on request.
REQ-011 The block SHALL have port flagh, output, 1 bit: current column lies in the visible region.
REQ-012 The block SHALL have port flagv, output, 1 bit: current line lies in the visible region.
REQ-013 The block SHALL have port hcount_reg, output, 10 bits: visible column index.
REQ-014 The block SHALL have port Vcount_reg, output, 9 bits: visible line index.
REQ-015 The block SHALL have port rgb_en, output, 1 bit: pixel output enable to the pixel generator.
REQ-016 The block SHALL have port hsync_n, output, 1 bit: horizontal sync to the panel, active-low.
REQ-017 The block SHALL have port vsync_n, output, 1 bit: vertical sync to the panel, active-low.
REQ-018 The block SHALL have port lcd_de, output, 1 bit: data enable to the panel.
REQ-019 The block SHALL have port disp, output, 1 bit: panel DISP pin.
REQ-020 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at frame origin.

Function
REQ-021 The block SHALL hold an internal h_pos that counts 0..H_TOTAL-1, where H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP (525 by default), and wraps to 0.
REQ-022 The block SHALL hold an internal v_pos that increments only on an h_pos wrap and counts 0..V_TOTAL-1, where V_TOTAL=286 by default, then wraps to 0.
REQ-023 The counters SHALL run continuously from reset release, independent of en and of the power state.
REQ-024 flagh SHALL be 1 iff h_pos is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1], which is 43..522 by default.
REQ-025 flagv SHALL be 1 iff v_pos is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1], which is 12..283 by default.
REQ-026 hcount_reg SHALL equal h_pos-(H_SYNC+H_BP) while flagh=1 and SHALL be 0 otherwise.
REQ-027 Vcount_reg SHALL equal v_pos-(V_SYNC+V_BP) while flagv=1 and SHALL be 0 otherwise.
REQ-028 flagh, flagv, hcount_reg and Vcount_reg SHALL be registered and mutually aligned, so that the first visible pixel shows hcount_reg=0 and the last shows 479.
REQ-029 The raw panel syncs SHALL be defined as: raw hsync_n=0 iff h_pos<H_SYNC; raw vsync_n=0 iff v_pos<V_SYNC.
REQ-030 hsync_n, vsync_n and lcd_de SHALL be the raw syncs and the raw (flagh&flagv) delayed by 2 clk_lcd cycles, matching the pixel generator's two-register pipeline.
REQ-031 lcd_de SHALL additionally be gated by rgb_en.
REQ-032 frame_start SHALL pulse high for exactly one cycle when h_pos=0 and v_pos=0, undelayed.
REQ-033 The power state machine SHALL have states OFF, WAIT and ON.
REQ-034 In OFF: disp=0 and rgb_en=0; the machine SHALL go to WAIT on the first frame_start with en=1.
REQ-035 In WAIT: disp=1 and rgb_en=0; the machine SHALL count frame_start pulses and go to ON on the PWR_FRAMES-th pulse.
REQ-036 In ON: disp=1 and rgb_en=1.
REQ-037 If en falls in ON, the machine SHALL stay in ON until the next frame_start, then go to OFF, so a frame is never truncated.
REQ-038 If en falls in WAIT, the machine SHALL go to OFF at the next frame_start and clear its frame count.
REQ-039 If en toggles within a single frame, only its value at a frame_start SHALL matter.
REQ-040 State transitions and the rgb_en and disp changes SHALL take effect on the cycle after the frame_start pulse.

Reset
REQ-041 While rst_n=0 the block SHALL hold h_pos=0, v_pos=0, flagh=0, flagv=0, hcount_reg=0, Vcount_reg=0, hsync_n=1, vsync_n=1, lcd_de=0, disp=0, rgb_en=0, frame_start=0, state=OFF and frame count=0.
REQ-042 Assertion of rst_n mid-frame or mid-line SHALL apply immediately and asynchronously.
REQ-043 Release of rst_n SHALL be sampled synchronously, and h_pos=0 SHALL be counted on the first clock edge after release.
REQ-044 The first frame_start SHALL occur on the first edge after reset release.

Verification
REQ-045 The bench SHALL apply reset then free-run 1 frame with en=0 and check: hsync_n low for 41 cycles every 525 cycles; vsync_n low for 10 lines of 286; disp=0, rgb_en=0, lcd_de=0.
REQ-046 The bench SHALL check, at the line boundary, that the cycle with h_pos=522 shows hcount_reg=479 and flagh=1, and that the cycle with h_pos=523 shows flagh=0 and hcount_reg=0.
REQ-047 The bench SHALL check at the frame wrap that line 283 shows Vcount_reg=271, that line 284 shows flagv=0, and that v_pos=285 -> 0 produces exactly one frame_start.
REQ-048 The bench SHALL set en=1 before the 2nd frame_start and check that disp rises after that pulse and that rgb_en rises after the 4th subsequent pulse (PWR_FRAMES=4).
REQ-049 The bench SHALL drop en mid-frame while in ON and check that rgb_en stays 1 until the next frame_start and that disp=0 after it.
REQ-050 The bench SHALL pulse rst_n low mid-line while in ON and check that all outputs take their reset values without waiting for a clock edge, and that the counters restart from 0 after release.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// lcd_timing_gen
//   Raster timing generator for a parallel RGB LCD panel, with a panel
//   power-sequencing state machine.
//
//   Ports
//     clk_lcd      in   pixel clock; all logic on its rising edge
//     rst_n        in   asynchronous active-low reset
//     en           in   display-on request, only looked at on frame_start
//     flagh        out  current column is visible
//     flagv        out  current line is visible
//     hcount_reg   out  visible column index (0 outside the visible region)
//     Vcount_reg   out  visible line index (0 outside the visible region)
//     rgb_en       out  pixel output enable to the pixel generator
//     hsync_n      out  horizontal sync, active-low, 2-cycle delayed
//     vsync_n      out  vertical sync, active-low, 2-cycle delayed
//     lcd_de       out  data enable, 2-cycle delayed and gated by rgb_en
//     disp         out  panel DISP pin
//     frame_start  out  one-cycle pulse at h_pos=0, v_pos=0
// -----------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter int unsigned H_SYNC     = 41,
    parameter int unsigned H_BP       = 2,
    parameter int unsigned H_ACTIVE   = 480,
    parameter int unsigned H_FP       = 2,
    parameter int unsigned V_SYNC     = 10,
    parameter int unsigned V_BP       = 2,
    parameter int unsigned V_ACTIVE   = 272,
    parameter int unsigned V_FP       = 2,
    parameter int unsigned PWR_FRAMES = 4
) (
    input  logic       clk_lcd,
    input  logic       rst_n,
    input  logic       en,
    output logic       flagh,
    output logic       flagv,
    output logic [9:0] hcount_reg,
    output logic [8:0] Vcount_reg,
    output logic       rgb_en,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       lcd_de,
    output logic       disp,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE - 1;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned V_END   = V_START + V_ACTIVE - 1;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned CW      = $clog2(PWR_FRAMES + 1);

    typedef enum logic [1:0] {
        PWR_OFF  = 2'd0,
        PWR_WAIT = 2'd1,
        PWR_ON   = 2'd2
    } pwr_state_t;

    // run is cleared by reset and set on the first edge after release, so
    // that edge "counts" position 0 instead of stepping past it.
    logic          run;
    logic [HW-1:0] h_pos, h_nxt, h_rel;
    logic [VW-1:0] v_pos, v_nxt, v_rel;
    logic          h_wrap;
    logic          in_h, in_v;
    logic          raw_hs_n, raw_vs_n, raw_de;
    logic [1:0]    hs_d, vs_d, de_d;

    pwr_state_t    state, state_nxt;
    logic [CW-1:0] frm_cnt, frm_cnt_nxt;

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    assign h_wrap = run && (h_pos == HW'(H_TOTAL - 1));

    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (run) begin
            h_nxt = h_wrap ? '0 : h_pos + HW'(1);
            v_nxt = v_pos;
            if (h_wrap)
                v_nxt = (v_pos == VW'(V_TOTAL - 1)) ? '0 : v_pos + VW'(1);
        end
    end

    // Visible-region decode is done on the next position so the registered
    // flags and indices line up with the registered h_pos/v_pos.
    assign in_h  = (h_nxt >= HW'(H_START)) && (h_nxt <= HW'(H_END));
    assign in_v  = (v_nxt >= VW'(V_START)) && (v_nxt <= VW'(V_END));
    assign h_rel = h_nxt - HW'(H_START);
    assign v_rel = v_nxt - VW'(V_START);

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
            flagh       <= 1'b0;
            flagv       <= 1'b0;
            hcount_reg  <= '0;
            Vcount_reg  <= '0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            h_pos       <= h_nxt;
            v_pos       <= v_nxt;
            flagh       <= in_h;
            flagv       <= in_v;
            hcount_reg  <= in_h ? 10'(h_rel) : '0;
            Vcount_reg  <= in_v ? 9'(v_rel) : '0;
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    // ------------------------------------------------------------------
    // Panel syncs: two register stages to match the pixel generator
    // ------------------------------------------------------------------
    assign raw_hs_n = !run || (h_pos >= HW'(H_SYNC));
    assign raw_vs_n = !run || (v_pos >= VW'(V_SYNC));
    assign raw_de   = flagh & flagv;

    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            hs_d <= '1;
            vs_d <= '1;
            de_d <= '0;
        end else begin
            hs_d <= {hs_d[0], raw_hs_n};
            vs_d <= {vs_d[0], raw_vs_n};
            de_d <= {de_d[0], raw_de};
        end
    end

    assign hsync_n = hs_d[1];
    assign vsync_n = vs_d[1];
    assign lcd_de  = de_d[1] & rgb_en;

    // ------------------------------------------------------------------
    // Power sequencing: en is only acted on at frame_start, so frames are
    // never cut short and mid-frame toggles are ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PWR_OFF;
            frm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            frm_cnt <= frm_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frm_cnt_nxt = frm_cnt;
        disp        = 1'b0;
        rgb_en      = 1'b0;
        case (state)
            PWR_OFF: begin
                frm_cnt_nxt = '0;
                if (frame_start && en)
                    state_nxt = PWR_WAIT;
            end
            PWR_WAIT: begin
                disp = 1'b1;
                if (frame_start) begin
                    if (!en) begin
                        state_nxt   = PWR_OFF;
                        frm_cnt_nxt = '0;
                    end else if (frm_cnt == CW'(PWR_FRAMES - 1)) begin
                        state_nxt   = PWR_ON;
                        frm_cnt_nxt = '0;
                    end else begin
                        frm_cnt_nxt = frm_cnt + CW'(1);
                    end
                end
            end
            PWR_ON: begin
                disp   = 1'b1;
                rgb_en = 1'b1;
                if (frame_start && !en)
                    state_nxt = PWR_OFF;
            end
            default: begin
                state_nxt   = PWR_OFF;
                frm_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_lcd_timing_gen
//   Bench for lcd_timing_gen using a reduced raster (22 x 13, 286 cycles per
//   frame). The reference is expressed in terms of the elapsed cycle index k
//   since reset release: position, sync and visibility follow from k by
//   division/modulo, and the panel power level follows from the number of
//   consecutive frame starts seen with en=1.
// -----------------------------------------------------------------------------
module tb_lcd_timing_gen;

    localparam int HS = 5,  HB = 3, HA = 12, HF = 2;
    localparam int VS = 3,  VB = 2, VA = 6,  VF = 2;
    localparam int PF = 4;
    localparam int HT = HS + HB + HA + HF;   // 22
    localparam int VT = VS + VB + VA + VF;   // 13
    localparam int FT = HT * VT;             // 286

    logic       clk_lcd = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       flagh, flagv, rgb_en, hsync_n, vsync_n, lcd_de, disp, frame_start;
    logic [9:0] hcount_reg;
    logic [8:0] Vcount_reg;

    lcd_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .PWR_FRAMES(PF)
    ) dut (
        .clk_lcd    (clk_lcd),
        .rst_n      (rst_n),
        .en         (en),
        .flagh      (flagh),
        .flagv      (flagv),
        .hcount_reg (hcount_reg),
        .Vcount_reg (Vcount_reg),
        .rgb_en     (rgb_en),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .lcd_de     (lcd_de),
        .disp       (disp),
        .frame_start(frame_start)
    );

    always #5 clk_lcd = ~clk_lcd;

    int vectors     = 0;
    int miscompares = 0;
    int mk          = -1;   // cycle index since release, -1 before first edge
    int streak      = 0;    // consecutive frame starts sampled with en=1

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at k=%0d: got %0d, expected %0d", name, mk, act, exp);
        end
    endtask

    function automatic int vis_h(input int h);
        return (h >= HS + HB && h < HS + HB + HA) ? 1 : 0;
    endfunction

    function automatic int vis_v(input int v);
        return (v >= VS + VB && v < VS + VB + VA) ? 1 : 0;
    endfunction

    // Reference time base and power level
    always @(posedge clk_lcd or negedge rst_n) begin
        if (!rst_n) begin
            mk     <= -1;
            streak <= 0;
        end else begin
            if (mk >= 0 && (mk % FT) == 0)
                streak <= en ? streak + 1 : 0;
            mk <= mk + 1;
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge clk_lcd) begin : compare
        int h, v, h2, v2;
        int e_fh, e_fv, e_hc, e_vc, e_hs, e_vs, e_de, e_disp, e_rgb, e_fs;
        if (!rst_n || mk < 0) begin
            e_fh = 0; e_fv = 0; e_hc = 0; e_vc = 0; e_hs = 1; e_vs = 1;
            e_de = 0; e_disp = 0; e_rgb = 0; e_fs = 0;
        end else begin
            h      = mk % HT;
            v      = (mk / HT) % VT;
            e_fh   = vis_h(h);
            e_fv   = vis_v(v);
            e_hc   = (e_fh == 1) ? h - (HS + HB) : 0;
            e_vc   = (e_fv == 1) ? v - (VS + VB) : 0;
            e_fs   = ((mk % FT) == 0) ? 1 : 0;
            e_disp = (streak >= 1) ? 1 : 0;
            e_rgb  = (streak >= PF + 1) ? 1 : 0;
            if (mk < 2) begin
                e_hs = 1; e_vs = 1; e_de = 0;
            end else begin
                h2   = (mk - 2) % HT;
                v2   = ((mk - 2) / HT) % VT;
                e_hs = (h2 >= HS) ? 1 : 0;
                e_vs = (v2 >= VS) ? 1 : 0;
                e_de = (vis_h(h2) == 1 && vis_v(v2) == 1 && e_rgb == 1) ? 1 : 0;
            end
        end
        check("flagh",       int'(flagh),       e_fh);
        check("flagv",       int'(flagv),       e_fv);
        check("hcount_reg",  int'(hcount_reg),  e_hc);
        check("Vcount_reg",  int'(Vcount_reg),  e_vc);
        check("hsync_n",     int'(hsync_n),     e_hs);
        check("vsync_n",     int'(vsync_n),     e_vs);
        check("lcd_de",      int'(lcd_de),      e_de);
        check("disp",        int'(disp),        e_disp);
        check("rgb_en",      int'(rgb_en),      e_rgb);
        check("frame_start", int'(frame_start), e_fs);
    end

    // Directed stimulus with hand-computed literal expectations
    initial begin
        int guard;
        int hs_low, vs_low, de_hi, fs_cnt;
        hs_low = 0; vs_low = 0; de_hi = 0; fs_cnt = 0;

        repeat (3) @(negedge clk_lcd);
        rst_n = 1'b1;

        // Phase 1: first frame with en=0, power-up, en drop in ON
        guard = 0;
        while (mk < 1800 && guard < 4000) begin
            @(negedge clk_lcd);
            guard++;
            if (mk >= 2 && mk <= 287) begin
                if (!hsync_n) hs_low++;
                if (!vsync_n) vs_low++;
                if (lcd_de)   de_hi++;
            end
            if (mk >= 280 && mk <= 291 && frame_start) fs_cnt++;
            if (mk == 0) begin
                check("lit_fs_first", int'(frame_start), 1);
                check("lit_hs_k0",    int'(hsync_n), 1);
            end
            if (mk == 2)  check("lit_hs_k2", int'(hsync_n), 0);
            if (mk == 6)  check("lit_hs_k6", int'(hsync_n), 0);
            if (mk == 7)  check("lit_hs_k7", int'(hsync_n), 1);
            if (mk == 19) begin
                check("lit_flagh_last",  int'(flagh), 1);
                check("lit_hcount_last", int'(hcount_reg), 11);
            end
            if (mk == 20) begin
                check("lit_flagh_fp",  int'(flagh), 0);
                check("lit_hcount_fp", int'(hcount_reg), 0);
            end
            if (mk == 100) begin
                check("lit_disp_off", int'(disp), 0);
                check("lit_rgb_off",  int'(rgb_en), 0);
            end
            if (mk == 200) en = 1'b1;
            if (mk == 228) begin
                check("lit_flagv_last",  int'(flagv), 1);
                check("lit_vcount_last", int'(Vcount_reg), 5);
            end
            if (mk == 250) begin
                check("lit_flagv_fp",  int'(flagv), 0);
                check("lit_vcount_fp", int'(Vcount_reg), 0);
            end
            if (mk == 286) check("lit_disp_at_pulse", int'(disp), 0);
            if (mk == 287) begin
                check("lit_disp_rise", int'(disp), 1);
                check("lit_rgb_wait",  int'(rgb_en), 0);
            end
            if (mk == 288) begin
                check("lit_hsync_low_frame", hs_low, 65);
                check("lit_vsync_low_frame", vs_low, 66);
                check("lit_de_high_frame",   de_hi, 0);
            end
            if (mk == 292)  check("lit_fs_wrap_count", fs_cnt, 1);
            if (mk == 1430) check("lit_rgb_before_on", int'(rgb_en), 0);
            if (mk == 1431) check("lit_rgb_on", int'(rgb_en), 1);
            if (mk == 1549) check("lit_de_before", int'(lcd_de), 0);
            if (mk == 1550) check("lit_de_first",  int'(lcd_de), 1);
            if (mk == 1600) en = 1'b0;
            if (mk == 1716) begin
                check("lit_rgb_hold", int'(rgb_en), 1);
                check("lit_disp_hold", int'(disp), 1);
            end
            if (mk == 1717) begin
                check("lit_rgb_drop",  int'(rgb_en), 0);
                check("lit_disp_drop", int'(disp), 0);
            end
            if (mk == 1800) en = 1'b1;
        end
        check("phase1_reached", mk, 1800);

        // Phase 2: power up again, then reset mid-line while ON
        guard = 0;
        while (mk < 3310 && guard < 4000) begin
            @(negedge clk_lcd);
            guard++;
            if (mk == 2002) check("lit_disp_p2_pulse", int'(disp), 0);
            if (mk == 2003) check("lit_disp_p2_rise", int'(disp), 1);
            if (mk == 3146) check("lit_rgb_p2_before", int'(rgb_en), 0);
            if (mk == 3147) check("lit_rgb_p2_on", int'(rgb_en), 1);
        end
        check("phase2_reached", mk, 3310);
        check("lit_pre_rst_flagh", int'(flagh), 1);
        check("lit_pre_rst_de",    int'(lcd_de), 1);
        check("lit_pre_rst_rgb",   int'(rgb_en), 1);

        #3 rst_n = 1'b0;
        #1;
        check("async_flagh",   int'(flagh), 0);
        check("async_flagv",   int'(flagv), 0);
        check("async_hcount",  int'(hcount_reg), 0);
        check("async_vcount",  int'(Vcount_reg), 0);
        check("async_hsync",   int'(hsync_n), 1);
        check("async_vsync",   int'(vsync_n), 1);
        check("async_de",      int'(lcd_de), 0);
        check("async_disp",    int'(disp), 0);
        check("async_rgb",     int'(rgb_en), 0);
        check("async_fs",      int'(frame_start), 0);

        repeat (2) @(negedge clk_lcd);
        rst_n = 1'b1;

        // Phase 3: restart from position 0 with en still high
        guard = 0;
        while (mk < 600 && guard < 2000) begin
            @(negedge clk_lcd);
            guard++;
            if (mk == 0) begin
                check("lit_restart_fs",   int'(frame_start), 1);
                check("lit_restart_disp", int'(disp), 0);
            end
            if (mk == 1) begin
                check("lit_restart_disp_rise", int'(disp), 1);
                check("lit_restart_fs_low",    int'(frame_start), 0);
            end
            if (mk == 2)  check("lit_restart_hs", int'(hsync_n), 0);
            if (mk == 19) check("lit_restart_hcount", int'(hcount_reg), 11);
            if (mk == 20) check("lit_restart_flagh", int'(flagh), 0);
        end
        check("phase3_reached", mk, 600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
